// File: rtl/cpu_axi_master_port_if.sv
// AXI4 master-port bundle carrying the five channels between
// the CPU request bridge and the interconnect.
interface cpu_axi_master_port_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    localparam int STRB = DATA_WIDTH / 8;

    logic [ID_WIDTH-1:0]   ARID;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [3:0]            ARLEN;
    logic [2:0]            ARSIZE;
    logic [1:0]            ARBURST;
    logic                  ARVALID;
    logic                  ARREADY;

    logic [ID_WIDTH-1:0]   RID;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RLAST;
    logic                  RVALID;
    logic                  RREADY;

    logic [ID_WIDTH-1:0]   AWID;
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [3:0]            AWLEN;
    logic [2:0]            AWSIZE;
    logic [1:0]            AWBURST;
    logic                  AWVALID;
    logic                  AWREADY;

    logic [DATA_WIDTH-1:0] WDATA;
    logic [STRB-1:0]       WSTRB;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;

    logic [ID_WIDTH-1:0]   BID;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY,
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY,
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );
endinterface

// File: rtl/cpu_axi_master_port.sv
// Bridges the core's single-word request port onto one AXI4
// master port as single-beat, non-interleaved transactions.
module cpu_axi_master_port #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MASTER_ID  = 0
) (
    input  logic                    ACLK,
    input  logic                    rst,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    input  logic [DATA_WIDTH/8-1:0] cpu_wstrb,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,
    output logic                    cpu_done,
    output logic                    cpu_err,
    output logic                    cpu_busy,
    cpu_axi_master_port_if.master   axi
);
    localparam int STRB = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RADDR,
        S_RDATA,
        S_WREQ,
        S_WRESP
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB-1:0]       r_wstrb;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_done;
    logic                  r_err;
    logic                  r_busy;
    logic                  r_arvalid;
    logic                  r_rready;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_bready;
    logic                  r_aw_done;
    logic                  r_w_done;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_fin;
    logic w_w_fin;
    logic w_unused;

    assign w_aw_hs  = r_awvalid & axi.AWREADY;
    assign w_w_hs   = r_wvalid & axi.WREADY;
    assign w_aw_fin = r_aw_done | w_aw_hs;
    assign w_w_fin  = r_w_done | w_w_hs;
    assign w_unused = ^{axi.RID, axi.BID, axi.RRESP[0], axi.BRESP[0]};

    assign axi.ARID    = ID_WIDTH'(MASTER_ID);
    assign axi.ARADDR  = r_addr;
    assign axi.ARLEN   = 4'd0;
    assign axi.ARSIZE  = 3'b010;
    assign axi.ARBURST = 2'b01;
    assign axi.ARVALID = r_arvalid;
    assign axi.RREADY  = r_rready;
    assign axi.AWID    = ID_WIDTH'(MASTER_ID);
    assign axi.AWADDR  = r_addr;
    assign axi.AWLEN   = 4'd0;
    assign axi.AWSIZE  = 3'b010;
    assign axi.AWBURST = 2'b01;
    assign axi.AWVALID = r_awvalid;
    assign axi.WDATA   = r_wdata;
    assign axi.WSTRB   = r_wstrb;
    assign axi.WLAST   = r_wvalid;
    assign axi.WVALID  = r_wvalid;
    assign axi.BREADY  = r_bready;

    assign cpu_rdata = r_rdata;
    assign cpu_done  = r_done;
    assign cpu_err   = r_err;
    assign cpu_busy  = r_busy;

    always_ff @(posedge ACLK) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (cpu_req) begin
                        r_addr  <= cpu_addr;
                        r_wdata <= cpu_wdata;
                        r_wstrb <= cpu_wstrb;
                        r_busy  <= 1'b1;
                        if (cpu_we) begin
                            r_state   <= S_WREQ;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                        end else begin
                            r_state   <= S_RADDR;
                            r_arvalid <= 1'b1;
                        end
                    end
                end
                S_RADDR: begin
                    if (axi.ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    // Non-last beats are absorbed; only RLAST completes
                    if (axi.RVALID) begin
                        r_rdata <= axi.RDATA;
                        if (axi.RLAST) begin
                            r_err    <= axi.RRESP[1];
                            r_done   <= 1'b1;
                            r_rready <= 1'b0;
                            r_busy   <= 1'b0;
                            r_state  <= S_IDLE;
                        end
                    end
                end
                S_WREQ: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_bready <= 1'b1;
                        r_state  <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (axi.BVALID) begin
                        r_err    <= axi.BRESP[1];
                        r_done   <= 1'b1;
                        r_bready <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_axi_master_port.sv
// Directed bench for cpu_axi_master_port driving the AXI slave
// side by hand, cycle by cycle.
module tb_cpu_axi_master_port;
    logic        ACLK = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic [31:0] cpu_rdata;
    logic        cpu_done;
    logic        cpu_err;
    logic        cpu_busy;

    int n_chk  = 0;
    int n_fail = 0;
    int n_aw   = 0;
    int n_w    = 0;

    cpu_axi_master_port_if #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)
    ) axi ();

    cpu_axi_master_port #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .ID_WIDTH(4), .MASTER_ID(0)
    ) dut (
        .ACLK(ACLK), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata),
        .cpu_done(cpu_done), .cpu_err(cpu_err),
        .cpu_busy(cpu_busy), .axi(axi)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        if (axi.AWVALID && axi.AWREADY) n_aw++;
        if (axi.WVALID && axi.WREADY) n_w++;
        @(posedge ACLK);
        #1;
    endtask

    task automatic req(input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_wstrb = s;
        tick();
        cpu_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0;
        cpu_wdata = 0; cpu_wstrb = 0;
        axi.ARREADY = 0; axi.RID = 0; axi.RDATA = 0;
        axi.RRESP = 0; axi.RLAST = 0; axi.RVALID = 0;
        axi.AWREADY = 0; axi.WREADY = 0;
        axi.BID = 0; axi.BRESP = 0; axi.BVALID = 0;
        tick(); tick();
        chk("rst_arvalid", 64'(axi.ARVALID), 0);
        chk("rst_awvalid", 64'(axi.AWVALID), 0);
        chk("rst_wvalid", 64'(axi.WVALID), 0);
        chk("rst_ready", 64'({axi.RREADY, axi.BREADY}), 0);
        chk("rst_cpu", 64'({cpu_done, cpu_err, cpu_busy}), 0);
        chk("rst_rdata", 64'(cpu_rdata), 0);
        rst = 1'b0;
        tick();

        // Zero-wait read
        req(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        chk("rd_arvalid", 64'(axi.ARVALID), 1);
        chk("rd_araddr", 64'(axi.ARADDR), 64'h10);
        chk("rd_arlen", 64'(axi.ARLEN), 0);
        chk("rd_arsize", 64'(axi.ARSIZE), 2);
        chk("rd_arburst", 64'(axi.ARBURST), 1);
        chk("rd_arid", 64'(axi.ARID), 0);
        chk("rd_busy", 64'(cpu_busy), 1);
        axi.ARREADY = 1;
        tick();
        axi.ARREADY = 0;
        chk("rd_arvalid_drop", 64'(axi.ARVALID), 0);
        chk("rd_rready", 64'(axi.RREADY), 1);
        axi.RVALID = 1; axi.RLAST = 1;
        axi.RDATA = 32'hDEAD_BEEF; axi.RRESP = 0;
        tick();
        axi.RVALID = 0; axi.RLAST = 0;
        chk("rd_done", 64'(cpu_done), 1);
        chk("rd_rdata", 64'(cpu_rdata), 64'hDEAD_BEEF);
        chk("rd_err", 64'(cpu_err), 0);
        chk("rd_idle", 64'({cpu_busy, axi.RREADY}), 0);
        tick();
        chk("rd_done_pulse", 64'(cpu_done), 0);

        // Write, AWREADY delayed, WREADY immediate
        n_aw = 0; n_w = 0;
        req(1'b1, 32'h0001_0004, 32'h1234_5678, 4'b0011);
        chk("w1_awvalid_c1", 64'(axi.AWVALID), 1);
        chk("w1_wvalid_c1", 64'(axi.WVALID), 1);
        chk("w1_wlast_c1", 64'(axi.WLAST), 1);
        chk("w1_wdata", 64'(axi.WDATA), 64'h1234_5678);
        chk("w1_wstrb", 64'(axi.WSTRB), 64'h3);
        chk("w1_awaddr_c1", 64'(axi.AWADDR), 64'h1_0004);
        axi.WREADY = 1;
        tick();
        axi.WREADY = 0;
        chk("w1_wvalid_c2", 64'(axi.WVALID), 0);
        chk("w1_awvalid_c2", 64'(axi.AWVALID), 1);
        tick();
        chk("w1_awvalid_c3", 64'(axi.AWVALID), 1);
        chk("w1_bready_c3", 64'(axi.BREADY), 0);
        tick();
        chk("w1_awvalid_c4", 64'(axi.AWVALID), 1);
        chk("w1_awaddr_c4", 64'(axi.AWADDR), 64'h1_0004);
        axi.AWREADY = 1;
        tick();
        axi.AWREADY = 0;
        chk("w1_awvalid_c5", 64'(axi.AWVALID), 0);
        chk("w1_bready_c5", 64'(axi.BREADY), 1);
        chk("w1_done_c5", 64'(cpu_done), 0);
        tick();
        chk("w1_bready_c6", 64'(axi.BREADY), 1);
        axi.BVALID = 1; axi.BRESP = 0;
        tick();
        axi.BVALID = 0;
        chk("w1_done", 64'(cpu_done), 1);
        chk("w1_err", 64'(cpu_err), 0);
        chk("w1_bready_off", 64'(axi.BREADY), 0);
        chk("w1_rdata_kept", 64'(cpu_rdata), 64'hDEAD_BEEF);
        chk("w1_n_aw", 64'(n_aw), 1);
        chk("w1_n_w", 64'(n_w), 1);

        // Write, WREADY delayed 2, AWREADY immediate
        n_aw = 0; n_w = 0;
        req(1'b1, 32'h0000_0020, 32'hA5A5_0001, 4'hF);
        axi.AWREADY = 1;
        tick();
        axi.AWREADY = 0;
        chk("w2_awvalid_c2", 64'(axi.AWVALID), 0);
        chk("w2_wvalid_c2", 64'(axi.WVALID), 1);
        chk("w2_wdata_c2", 64'(axi.WDATA), 64'hA5A5_0001);
        tick();
        chk("w2_wlast_c3", 64'(axi.WLAST), 1);
        axi.WREADY = 1;
        tick();
        axi.WREADY = 0;
        chk("w2_wvalid_c4", 64'(axi.WVALID), 0);
        chk("w2_bready_c4", 64'(axi.BREADY), 1);
        axi.BVALID = 1;
        tick();
        axi.BVALID = 0;
        chk("w2_done", 64'(cpu_done), 1);
        chk("w2_n_aw", 64'(n_aw), 1);
        chk("w2_n_w", 64'(n_w), 1);

        // Same-cycle AW/W with zero strobes
        n_aw = 0; n_w = 0;
        req(1'b1, 32'h0000_0030, 32'h0BAD_F00D, 4'h0);
        chk("w3_both_valid", 64'({axi.AWVALID, axi.WVALID}), 3);
        chk("w3_wstrb", 64'(axi.WSTRB), 0);
        chk("w3_wlast", 64'(axi.WLAST), 1);
        axi.AWREADY = 1; axi.WREADY = 1;
        tick();
        axi.AWREADY = 0; axi.WREADY = 0;
        chk("w3_valids_off", 64'({axi.AWVALID, axi.WVALID}), 0);
        chk("w3_bready", 64'(axi.BREADY), 1);
        axi.BVALID = 1;
        tick();
        axi.BVALID = 0;
        chk("w3_done", 64'(cpu_done), 1);
        chk("w3_n_aw", 64'(n_aw), 1);
        chk("w3_n_w", 64'(n_w), 1);

        // SLVERR read, then non-last beat and clean read
        req(1'b0, 32'h0000_0040, 32'h0, 4'h0);
        axi.ARREADY = 1;
        tick();
        axi.ARREADY = 0;
        axi.RVALID = 1; axi.RLAST = 1;
        axi.RDATA = 32'hE0E0_0000; axi.RRESP = 2'b10;
        tick();
        axi.RVALID = 0; axi.RLAST = 0; axi.RRESP = 0;
        chk("er_done", 64'(cpu_done), 1);
        chk("er_err", 64'(cpu_err), 1);
        tick();
        chk("er_err_held", 64'(cpu_err), 1);
        req(1'b0, 32'h0000_0044, 32'h0, 4'h0);
        axi.ARREADY = 1;
        tick();
        axi.ARREADY = 0;
        axi.RVALID = 1; axi.RLAST = 0;
        axi.RDATA = 32'h1111_1111;
        tick();
        chk("nl_stay", 64'({axi.RREADY, cpu_done}), 64'b10);
        chk("nl_rdata", 64'(cpu_rdata), 64'h1111_1111);
        axi.RLAST = 1; axi.RDATA = 32'h2222_2222;
        tick();
        axi.RVALID = 0; axi.RLAST = 0;
        chk("ok_done", 64'(cpu_done), 1);
        chk("ok_err_clr", 64'(cpu_err), 0);
        chk("ok_rdata", 64'(cpu_rdata), 64'h2222_2222);
        tick();

        // Back-to-back reads with cpu_req held
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0050;
        tick();
        chk("bb_ar1", 64'(axi.ARVALID), 1);
        axi.ARREADY = 1;
        tick();
        axi.ARREADY = 0;
        chk("bb_busy_c2", 64'(cpu_busy), 1);
        axi.RVALID = 1; axi.RLAST = 1;
        axi.RDATA = 32'hB0B0_0001;
        tick();
        axi.RVALID = 0; axi.RLAST = 0;
        chk("bb_done1", 64'(cpu_done), 1);
        chk("bb_busy_gap", 64'(cpu_busy), 0);
        chk("bb_ar_gap", 64'(axi.ARVALID), 0);
        tick();
        chk("bb_ar2", 64'(axi.ARVALID), 1);
        chk("bb_busy_c4", 64'(cpu_busy), 1);
        chk("bb_done_off", 64'(cpu_done), 0);
        axi.ARREADY = 1;
        tick();
        axi.ARREADY = 0;
        axi.RVALID = 1; axi.RLAST = 1;
        axi.RDATA = 32'hB0B0_0002;
        tick();
        axi.RVALID = 0; axi.RLAST = 0;
        cpu_req = 0;
        chk("bb_done2", 64'(cpu_done), 1);
        chk("bb_rdata2", 64'(cpu_rdata), 64'hB0B0_0002);
        tick();
        chk("bb_idle", 64'({cpu_busy, axi.ARVALID}), 0);

        // Reset while waiting in RDATA
        req(1'b0, 32'h0000_0060, 32'h0, 4'h0);
        axi.ARREADY = 1;
        tick();
        axi.ARREADY = 0;
        chk("rs_rready", 64'(axi.RREADY), 1);
        rst = 1;
        tick();
        rst = 0;
        chk("rs_arvalid", 64'(axi.ARVALID), 0);
        chk("rs_rready_off", 64'(axi.RREADY), 0);
        chk("rs_busy", 64'(cpu_busy), 0);
        chk("rs_done", 64'(cpu_done), 0);
        chk("rs_rdata", 64'(cpu_rdata), 0);
        tick();
        chk("rs_done_after", 64'(cpu_done), 0);
        chk("rs_busy_after", 64'(cpu_busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_axi_master_port.md
Name: cpu_axi_master_port

Overview:
- Converts the CPU core's single-word memory request interface into AXI4 single-beat transactions on one master port of CPU_wrapper.
- Instantiated twice:
  - M0: instruction fetch, read-only; write request inputs tied low.
  - M1: data, read and write.
- Sits directly upstream of the M0/M1 AXI ports.
- Must pass the AXI master protocol monitors with MAXLEN=1 and no interleaving.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; STRB = DATA_WIDTH/8.
- ID_WIDTH, 4, width of AXI ID fields.
- MASTER_ID, 0, constant driven on ARID/AWID.

Ports:
- ACLK  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cpu_req  in  1  request strobe; sampled only in IDLE.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_WIDTH  byte address, passed through unmodified.
- cpu_wdata  in  DATA_WIDTH  write data.
- cpu_wstrb  in  STRB  write byte enables.
- cpu_rdata  out  DATA_WIDTH  last completed read data.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_err  out  1  response error flag, valid with cpu_done.
- cpu_busy  out  1  high whenever state != IDLE.
- ARID/ARADDR/ARLEN[3:0]/ARSIZE[2:0]/ARBURST[1:0]/ARVALID  out  AXI read address channel.
- ARREADY  in  1  read address ready.
- RID[ID]/RDATA/RRESP[1:0]/RLAST/RVALID  in  AXI read data channel.
- RREADY  out  1  read data ready.
- AWID/AWADDR/AWLEN[3:0]/AWSIZE[2:0]/AWBURST[1:0]/AWVALID  out  AXI write address channel.
- AWREADY  in  1  write address ready.
- WDATA/WSTRB/WLAST/WVALID  out  AXI write data channel.
- WREADY  in  1  write data ready.
- BID[ID]/BRESP[1:0]/BVALID  in  AXI write response channel.
- BREADY  out  1  write response ready.

Behaviour:
- Constant outputs:
  - ARLEN = AWLEN = 0.
  - ARSIZE = AWSIZE = 3'b010.
  - ARBURST = AWBURST = 2'b01.
  - ARID = AWID = MASTER_ID.
  - WLAST = WVALID.
- Reset (synchronous, takes effect at the next ACLK edge):
  - state = IDLE.
  - All VALID/READY outputs, cpu_done, cpu_err, cpu_busy = 0.
  - cpu_rdata and the latched addr/wdata/wstrb registers = 0.
  - Reset mid-transaction abandons the transaction silently; no cpu_done is issued.
- FSM states: IDLE, RADDR, RDATA, WREQ, WRESP.
- IDLE:
  - On cpu_req=1, latch cpu_we/addr/wdata/wstrb.
  - Go to RADDR (we=0) or WREQ (we=1).
  - cpu_req while busy is ignored; the CPU holds it.
- RADDR:
  - ARVALID=1, ARADDR = latched address, held stable until ARREADY.
  - ARVALID & ARREADY -> RDATA; ARVALID=0 the next cycle.
- RDATA:
  - RREADY=1.
  - On RVALID & RLAST: cpu_rdata <= RDATA; cpu_err <= RRESP[1]; cpu_done=1 next cycle; -> IDLE.
  - A beat with RVALID & ~RLAST is accepted and its data latched, but the FSM stays in RDATA.
- WREQ:
  - AWVALID=1 and WVALID=1 are asserted together on entry.
  - Flags aw_done/w_done record each handshake; each VALID drops the cycle after its own handshake.
  - Handshakes may occur in either order or in the same cycle.
  - -> WRESP once both are done, including the same-cycle case.
  - WDATA/WSTRB/AWADDR are held stable until their handshakes.
- WRESP:
  - BREADY=1.
  - On BVALID: cpu_err <= BRESP[1]; cpu_done next cycle; -> IDLE.
  - cpu_rdata is unchanged by writes.
- Completion timing:
  - cpu_done is registered and high exactly one cycle, coinciding with the first IDLE cycle, when cpu_busy=0.
  - cpu_req in that cycle is accepted (back-to-back).
- RID/BID are not compared.
- cpu_wstrb=0 still issues a full AXI write.
- Latency (zero-wait slave):
  - Read: req cycle 0, ARVALID cycle 1, RREADY cycle 2, cpu_done cycle 3.
  - Write: cpu_done at cycle 3 if AW, W and B complete on the earliest cycles.
- cpu_err is held until the next completion.

Test Plan:
- Read, zero-wait slave, addr=0x0000_0010, RDATA=0xDEAD_BEEF, RRESP=0:
  - ARVALID at cycle 1 with ARADDR=0x10, ARLEN=0, ARSIZE=2, ARBURST=1.
  - cpu_done at cycle 3 with cpu_rdata=0xDEAD_BEEF and cpu_err=0.
- Write addr=0x0001_0004, wdata=0x1234_5678, wstrb=4'b0011, with AWREADY delayed 3 cycles and WREADY immediate:
  - WVALID drops after cycle 1.
  - AWVALID is held with a stable AWADDR until cycle 4.
  - BREADY is high from cycle 5.
  - cpu_done follows BVALID by one cycle.
- Write with WREADY delayed 2 cycles and AWREADY immediate, then the same-cycle AW/W case:
  - In both, exactly one AW handshake and one W handshake occur, and WLAST=1.
- Read with RRESP=2'b10 (SLVERR):
  - cpu_done with cpu_err=1.
  - The following successful read clears cpu_err to 0.
- Back-to-back reads with cpu_req held high:
  - Second ARVALID appears one cycle after the first cpu_done.
  - cpu_busy is low for exactly one cycle between the two reads.
- rst asserted in RDATA before RVALID:
  - Next cycle ARVALID=RREADY=cpu_busy=0 and no cpu_done is issued.
  - cpu_rdata=0.
